// File: rtl/filter_pkg.sv
// Shared types and widths for the median filter sequencer.
//   state_e  : sequencer FSM states
//   result_t : captured filter result (select code + data)
package filter_pkg;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned FILT_ADDR_W = 3;
    localparam int unsigned FILT_SEL_W  = 2;
    localparam int unsigned MAX_TAPS    = 8;
    // Fill count must be able to hold MAX_TAPS itself.
    localparam int unsigned FILL_W      = $clog2(MAX_TAPS + 1);
    // Read-latency wait counter, READ_LAT up to 4.
    localparam int unsigned WAIT_W      = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_SELECT  = 2'd2,
        ST_PRESENT = 2'd3
    } state_e;

    typedef struct packed {
        logic [FILT_SEL_W-1:0] sel;
        logic [DATA_W-1:0]     data;
    } result_t;

endpackage

// File: rtl/seq_wrap_counter.sv
// Modulo-N counter with synchronous clear and increment.
//   clk, rst  : clock, async active-low reset
//   clr       : clear to 0 (wins over inc)
//   inc       : advance by one, wrapping N-1 -> 0
//   count     : current value
//   last_c    : count is at N-1 (next inc wraps)
module seq_wrap_counter #(
    parameter int unsigned N = 2,
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         last_c
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign last_c = (count_q == W'(N - 1));
    assign count  = count_q;

    // Next-count selection.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = last_c ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/filter_sequencer.sv
// Sequences the median filter: writes incoming samples round-robin into the
// filter register window, then, once the window is full, steps out_select
// through every result code and presents each result on a valid/ready port.
//   clk, rst                 : clock, async active-low reset
//   flush                    : synchronous window clear / burst abort
//   in_valid/in_data/in_ready: sample input handshake
//   f_*                      : filter register write and output-select control
//   res_valid/res_data/res_sel/res_ready : result output handshake
//   window_full, busy        : status
module filter_sequencer
    import filter_pkg::*;
#(
    parameter int unsigned NUM_TAPS = 5,
    parameter int unsigned NUM_OUT  = 3,
    parameter int unsigned READ_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   in_ready,
    output logic                   f_wr_enable,
    output logic [FILT_ADDR_W-1:0] f_reg_addr,
    output logic [DATA_W-1:0]      f_data_in,
    output logic [FILT_SEL_W-1:0]  f_out_select,
    input  logic [DATA_W-1:0]      f_data_out,
    output logic                   res_valid,
    output logic [DATA_W-1:0]      res_data,
    output logic [FILT_SEL_W-1:0]  res_sel,
    input  logic                   res_ready,
    output logic                   window_full,
    output logic                   busy
);

    state_e                 state_q, state_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [FILT_ADDR_W-1:0] waddr_q, waddr_d;
    result_t                res_q, res_d;
    logic                   wr_en_q, wr_en_d;
    logic                   res_valid_q, res_valid_d;
    logic                   full_q, full_d;
    logic                   busy_q, busy_d;

    logic [FILT_ADDR_W-1:0] wptr;
    logic                   wptr_last_c;
    logic                   wptr_clr, wptr_inc;
    logic [FILT_SEL_W-1:0]  sel;
    logic                   sel_last_c;
    logic                   sel_clr, sel_inc;

    // Write pointer into the filter window.
    seq_wrap_counter #(
        .N (NUM_TAPS),
        .W (FILT_ADDR_W)
    ) u_wptr (
        .clk    (clk),
        .rst    (rst),
        .clr    (wptr_clr),
        .inc    (wptr_inc),
        .count  (wptr),
        .last_c (wptr_last_c)
    );

    // Output-select code for the current burst.
    seq_wrap_counter #(
        .N (NUM_OUT),
        .W (FILT_SEL_W)
    ) u_sel (
        .clk    (clk),
        .rst    (rst),
        .clr    (sel_clr),
        .inc    (sel_inc),
        .count  (sel),
        .last_c (sel_last_c)
    );

    // Ready only while idle; flush blocks acceptance in the same cycle, and
    // reset gating keeps it low while rst is held.
    assign in_ready     = rst && (state_q == ST_IDLE) && !flush;
    assign f_wr_enable  = wr_en_q;
    assign f_reg_addr   = waddr_q;
    assign f_data_in    = wdata_q;
    assign f_out_select = sel;
    assign res_valid    = res_valid_q;
    assign res_data     = res_q.data;
    assign res_sel      = res_q.sel;
    assign window_full  = full_q;
    assign busy         = busy_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        wait_d   = wait_q;
        wdata_d  = wdata_q;
        waddr_d  = waddr_q;
        res_d    = res_q;
        wptr_clr = 1'b0;
        wptr_inc = 1'b0;
        sel_clr  = 1'b0;
        sel_inc  = 1'b0;

        if (flush) begin
            state_d  = ST_IDLE;
            fill_d   = '0;
            wptr_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        wdata_d = in_data;
                        waddr_d = wptr;
                        state_d = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    wptr_inc = 1'b1;
                    // fill tracks wptr from empty, so a wrapping write means full.
                    if ((fill_q == FILL_W'(NUM_TAPS)) || wptr_last_c) begin
                        fill_d = FILL_W'(NUM_TAPS);
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                    if (fill_d < FILL_W'(NUM_TAPS)) begin
                        state_d = ST_IDLE;
                    end else begin
                        sel_clr = 1'b1;
                        wait_d  = '0;
                        state_d = ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    // Capture after data_out has had READ_LAT cycles to settle.
                    if (wait_q == WAIT_W'(READ_LAT - 1)) begin
                        res_d.sel  = sel;
                        res_d.data = f_data_out;
                        state_d    = ST_PRESENT;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                ST_PRESENT: begin
                    if (res_ready) begin
                        if (sel_last_c) begin
                            state_d = ST_IDLE;
                        end else begin
                            sel_inc = 1'b1;
                            wait_d  = '0;
                            state_d = ST_SELECT;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        wr_en_d     = (state_d == ST_WRITE);
        res_valid_d = (state_d == ST_PRESENT);
        busy_d      = (state_d != ST_IDLE);
        full_d      = (fill_d == FILL_W'(NUM_TAPS));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            fill_q      <= '0;
            wait_q      <= '0;
            wdata_q     <= '0;
            waddr_q     <= '0;
            res_q       <= '0;
            wr_en_q     <= 1'b0;
            res_valid_q <= 1'b0;
            full_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            wait_q      <= wait_d;
            wdata_q     <= wdata_d;
            waddr_q     <= waddr_d;
            res_q       <= res_d;
            wr_en_q     <= wr_en_d;
            res_valid_q <= res_valid_d;
            full_q      <= full_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_filter_sequencer.sv
// Bench for filter_sequencer: emulates the median filter on the f_* port and
// checks writes and result bursts against a sliding-window reference model.
module tb_filter_sequencer;

    localparam int NT = 5;
    localparam int NO = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       res_ready = 1'b0;
    logic       in_ready;
    logic       f_wr_enable;
    logic [2:0] f_reg_addr;
    logic [7:0] f_data_in;
    logic [1:0] f_out_select;
    logic [7:0] f_data_out;
    logic       res_valid;
    logic [7:0] res_data;
    logic [1:0] res_sel;
    logic       window_full;
    logic       busy;

    int errors = 0;
    int checks = 0;

    // Reference model: sample window, write pointer and fill since last clear.
    logic [7:0] model_win [NT];
    int         model_wptr = 0;
    int         model_fill = 0;

    // Emulated filter register file.
    logic [7:0] fregs [NT];

    filter_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .f_wr_enable  (f_wr_enable),
        .f_reg_addr   (f_reg_addr),
        .f_data_in    (f_data_in),
        .f_out_select (f_out_select),
        .f_data_out   (f_data_out),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_sel      (res_sel),
        .res_ready    (res_ready),
        .window_full  (window_full),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Filter result codes: 0 median, 1 min, 2 max, 3 zero.
    function automatic logic [7:0] filt(input logic [7:0] w [NT], input logic [1:0] code);
        logic [7:0] s [NT];
        logic [7:0] t;
        s = w;
        for (int i = 0; i < NT - 1; i++) begin
            for (int j = 0; j < NT - 1 - i; j++) begin
                if (s[j] > s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
            end
        end
        case (code)
            2'd0:    return s[NT/2];
            2'd1:    return s[0];
            2'd2:    return s[NT-1];
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (f_wr_enable && (f_reg_addr < 3'(NT))) fregs[f_reg_addr] <= f_data_in;
    end

    always_comb f_data_out = filt(fregs, f_out_select);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},     32'(in_ready), 0);
        chk({tag, "_wr_enable"},    32'(f_wr_enable), 0);
        chk({tag, "_reg_addr"},     32'(f_reg_addr), 0);
        chk({tag, "_data_in"},      32'(f_data_in), 0);
        chk({tag, "_out_select"},   32'(f_out_select), 0);
        chk({tag, "_res_valid"},    32'(res_valid), 0);
        chk({tag, "_res_data"},     32'(res_data), 0);
        chk({tag, "_res_sel"},      32'(res_sel), 0);
        chk({tag, "_window_full"},  32'(window_full), 0);
        chk({tag, "_busy"},         32'(busy), 0);
    endtask

    // Offer one sample; returns at the negedge of the WRITE cycle.
    task automatic send(input logic [7:0] d);
        int n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        chk("in_ready_wait", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        chk("wr_enable", 32'(f_wr_enable), 1);
        chk("wr_addr",   32'(f_reg_addr), 32'(model_wptr));
        chk("wr_data",   32'(f_data_in), 32'(d));
        model_win[model_wptr] = d;
        model_wptr = (model_wptr + 1) % NT;
        if (model_fill < NT) model_fill++;
    endtask

    task automatic after_write_idle();
        @(negedge clk);
        chk("idle_in_ready",    32'(in_ready), 1);
        chk("idle_res_valid",   32'(res_valid), 0);
        chk("idle_window_full", 32'(window_full), 0);
        chk("idle_wr_enable",   32'(f_wr_enable), 0);
    endtask

    task automatic wait_res();
        int n = 0;
        while (!res_valid && n < 20) begin @(negedge clk); n++; end
        chk("res_valid_wait", 32'(res_valid), 1);
    endtask

    // Consume a full result burst; optionally stall the first result.
    task automatic burst(input int hold, input bit rand_ready);
        logic [7:0] exp_d;
        int         d;
        for (int j = 0; j < NO; j++) begin
            wait_res();
            exp_d = filt(model_win, 2'(j));
            chk("res_sel",      32'(res_sel), 32'(j));
            chk("res_data",     32'(res_data), 32'(exp_d));
            chk("out_select",   32'(f_out_select), 32'(j));
            chk("burst_full",   32'(window_full), 1);
            chk("burst_ready",  32'(in_ready), 0);
            d = (j == 0) ? hold : (rand_ready ? int'($urandom_range(0, 3)) : 0);
            for (int c = 0; c < d; c++) begin
                @(negedge clk);
                chk("hold_valid",    32'(res_valid), 1);
                chk("hold_data",     32'(res_data), 32'(exp_d));
                chk("hold_sel",      32'(res_sel), 32'(j));
                chk("hold_in_ready", 32'(in_ready), 0);
                chk("hold_wr_en",    32'(f_wr_enable), 0);
            end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
        chk("burst_end_busy",  32'(busy), 0);
        chk("burst_end_ready", 32'(in_ready), 1);
    endtask

    initial begin
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 1);

        // Fill phase: no results until the window is full.
        for (int i = 1; i <= 4; i++) begin
            send(8'(i * 16));
            after_write_idle();
        end

        // Window full: first burst, then wrap-around write to addr 0.
        send(8'h50);
        burst(0, 1'b0);
        send(8'h05);
        burst(0, 1'b0);

        // Back-pressure on the first result of a burst.
        send(8'($urandom));
        burst(10, 1'b0);

        // Random sliding-window bursts with random consumer stalls.
        for (int i = 0; i < 6; i++) begin
            send(8'($urandom));
            burst(0, 1'b1);
        end

        // Flush mid-burst while the second result is presented.
        send(8'hA1);
        wait_res();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        wait_res();
        chk("flush_pre_sel", 32'(res_sel), 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_res_valid",   32'(res_valid), 0);
        chk("flush_busy",        32'(busy), 0);
        chk("flush_window_full", 32'(window_full), 0);
        model_fill = 0;
        model_wptr = 0;

        // Flush wins over a simultaneous sample.
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        #1;
        chk("flush_blocks_ready", 32'(in_ready), 0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_no_write", 32'(f_wr_enable), 0);
        chk("flush_no_busy",  32'(busy), 0);
        send(8'h77);
        after_write_idle();

        // Asynchronous reset while in WRITE.
        send(8'h88);
        #1;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_fill = 0;
        model_wptr = 0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_release_ready", 32'(in_ready), 1);
        send(8'h99);
        after_write_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/filter_sequencer.md
Name: filter_sequencer

Overview:
- Controller that sequences the median filter datapath.
- Accepts an 8-bit sample stream over a valid/ready handshake and writes each sample into the filter's register window, round-robin.
- Once the window is full, steps the filter's output selector through each result code and presents every result on a valid/ready output.
- Sits between the pad-side input logic and the filter instance in the top level; owns the filter's wr_enable, reg_addr, data_in and out_select.

Parameters:
- NUM_TAPS, 5, number of filter registers in the sliding window (addresses 0..NUM_TAPS-1); legal range 1..8.
- NUM_OUT, 3, number of out_select codes read per result burst (codes 0..NUM_OUT-1); legal range 1..4.
- READ_LAT, 1, cycles from an out_select change until filter data_out is stable; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- flush  in  1  synchronous window clear, active high.
- in_valid  in  1  sample valid.
- in_data  in  8  sample value.
- in_ready  out  1  sample accepted on the edge where in_valid & in_ready.
- f_wr_enable  out  1  filter register write strobe.
- f_reg_addr  out  3  filter register address.
- f_data_in  out  8  filter write data.
- f_out_select  out  2  filter output selector.
- f_data_out  in  8  filter result.
- res_valid  out  1  result valid.
- res_data  out  8  captured result.
- res_sel  out  2  out_select code that produced res_data.
- res_ready  in  1  result consumer ready.
- window_full  out  1  fill count has reached NUM_TAPS.
- busy  out  1  FSM state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE; wptr, fill, sel and wait counter cleared to 0.
  - Outputs under reset: in_ready=0, f_wr_enable=0, f_reg_addr=0, f_data_in=0, f_out_select=0, res_valid=0, res_data=0, res_sel=0, window_full=0, busy=0.
  - After release: in_ready=1 from the first cycle.
- FSM states: IDLE, WRITE, SELECT, PRESENT.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_data into f_data_in, drive f_reg_addr=wptr, go to WRITE.
- WRITE (exactly 1 cycle):
  - f_wr_enable=1.
  - wptr wraps from NUM_TAPS-1 to 0.
  - fill increments, saturating at NUM_TAPS.
  - If the updated fill < NUM_TAPS: go to IDLE.
  - Otherwise: sel=0 and go to SELECT.
- SELECT:
  - f_out_select=sel.
  - Waits READ_LAT cycles, then captures res_data=f_data_out and res_sel=sel, and goes to PRESENT.
- PRESENT:
  - res_valid=1; res_data and res_sel held stable while res_ready=0.
  - On res_valid & res_ready: if sel==NUM_OUT-1 go to IDLE, else sel+1 and go to SELECT.
- Latency (READ_LAT=1): sample accepted at edge k -> f_wr_enable high in cycle k+1 -> select applied in k+2 -> res_valid in k+3.
- f_out_select holds its last value outside SELECT and PRESENT.
- f_wr_enable is high only in WRITE.
- window_full=(fill==NUM_TAPS).
- in_ready=0 in every state except IDLE; no sample is ever dropped or overwritten.
- flush=1:
  - Next edge clears fill and wptr, deasserts res_valid, and returns to IDLE from any state.
  - Aborts a burst mid-way; a partially presented result is discarded.
  - flush wins over a simultaneous in_valid: the sample is not accepted, because in_ready is forced to 0 while flush=1.
- Once full, every new sample triggers a full NUM_OUT burst; the window slides, overwriting the oldest register.

Decomposition:
- Shared package filter_pkg holds:
  - state enum constants ST_IDLE, ST_WRITE, ST_SELECT, ST_PRESENT (2-bit encoding);
  - FILT_ADDR_W=3, FILT_SEL_W=2, DATA_W=8;
  - max-tap constant 8.
- One sub-module, seq_wrap_counter: parameterised modulo-N counter with clear, increment and wrap flag; instantiated for wptr and sel.
- FSM, fill saturation and handshake logic stay in filter_sequencer.

Test Plan:
- Reset then 4 samples 0x10,0x20,0x30,0x40 -> writes to addr 0..3 with matching data; window_full=0; res_valid never asserted; in_ready=1 after each write.
- 5th sample 0x50 (defaults) -> write addr 4; f_out_select steps 0,1,2; three results presented; res_sel=0,1,2; res_data equals the model filter output; window_full=1.
- 6th sample 0x05 -> write to addr 0 (wrap-around); new burst of 3 results computed over window {05,20,30,40,50}.
- Hold res_ready=0 for 10 cycles during PRESENT -> res_valid, res_data and res_sel stable; in_ready=0; f_wr_enable=0 throughout.
- Assert flush while sel=1 in PRESENT -> res_valid=0 next cycle; FSM in IDLE; window_full=0; next sample written to addr 0.
- Assert rst=0 asynchronously during WRITE -> f_wr_enable falls immediately; all outputs take reset values; after release, first sample goes to addr 0.
